vga_scan_gen: RTL and testbench

- Raster-scan timing generator that drives pixel coordinates into the sprite/background pixel sources.
- Collects the RGB those sources return and drives the VGA pins (RGB, HS, VS, BLANK_N), with sync and blank delayed to match the source latency.
- Emits a one-cycle frame tick for game-logic updates during vertical blank.
- Sits between the pixel sources and the VGA DAC. It is the counterpart of the coordinate-in/RGB-out sprite blocks.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_pipe_delay.sv | 30 +++
 rtl/vga_scan_gen.sv | 140 ++++++++++++++
 tb/tb_vga_scan_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and coordinate width for the
// scan generator and the pixel-source blocks that consume its coordinates.
package vga_timing_pkg;

    localparam int COORD_W = 11;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    function automatic logic [COORD_W-1:0] to_coord(input int value);
        return COORD_W'(value);
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// WIDTH x DEPTH shift register with synchronous active-low clear; DEPTH >= 1.
module vga_pipe_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per clock; clear to all-inactive on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing generator: issues pixel coordinates, then drives RGB/sync/blank
// pins delayed by PIPE+1 clocks so they line up with the pixel-source latency.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIPE     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         iR,
    input  logic [7:0]         iG,
    input  logic [7:0]         iB,
    output logic [COORD_W-1:0] ox,
    output logic [COORD_W-1:0] oy,
    output logic [7:0]         oVGA_R,
    output logic [7:0]         oVGA_G,
    output logic [7:0]         oVGA_B,
    output logic               oHS,
    output logic               oVS,
    output logic               oBLANK_N,
    output logic               oFrame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST    = to_coord(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = to_coord(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_C   = to_coord(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C   = to_coord(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_PRE_BLK = to_coord(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] HS_START  = to_coord(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = to_coord(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START  = to_coord(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = to_coord(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_totals
        $error("vga_scan_gen: H_TOTAL/V_TOTAL exceed the 11-bit coordinate range");
    end
    if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
        $error("vga_scan_gen: PIPE must lie in 0..7");
    end

    logic [COORD_W-1:0] h_r;
    logic [COORD_W-1:0] v_r;
    logic               frame_r;
    logic               active_s;
    logic               hs_raw_s;
    logic               vs_raw_s;
    logic [2:0]         tap_in_s;
    logic [2:0]         tap_out_s;
    logic [7:0]         red_r;
    logic [7:0]         grn_r;
    logic [7:0]         blu_r;
    logic               hs_r;
    logic               vs_r;
    logic               blank_n_r;

    // Raster counters; the frame tick is decoded from the next counter state
    // so it is high in the very cycle the counters read (0, V_ACTIVE).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_r     <= '0;
            v_r     <= '0;
            frame_r <= 1'b0;
        end else begin
            frame_r <= (h_r == H_LAST) && (v_r == V_PRE_BLK);
            if (h_r == H_LAST) begin
                h_r <= '0;
                v_r <= (v_r == V_LAST) ? '0 : v_r + 11'd1;
            end else begin
                h_r <= h_r + 11'd1;
            end
        end
    end

    assign active_s = (h_r < H_ACT_C) && (v_r < V_ACT_C);
    assign hs_raw_s = (h_r >= HS_START) && (h_r < HS_END);
    assign vs_raw_s = (v_r >= VS_START) && (v_r < VS_END);
    assign tap_in_s = {active_s, hs_raw_s, vs_raw_s};

    if (PIPE == 0) begin : g_no_delay
        assign tap_out_s = tap_in_s;
    end else begin : g_delay
        vga_pipe_delay #(
            .WIDTH (3),
            .DEPTH (PIPE)
        ) u_delay (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (tap_in_s),
            .dout  (tap_out_s)
        );
    end

    // Pin register: RGB only passes while the delayed timeline is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_r     <= 8'd0;
            grn_r     <= 8'd0;
            blu_r     <= 8'd0;
            hs_r      <= ~SYNC_POL;
            vs_r      <= ~SYNC_POL;
            blank_n_r <= 1'b0;
        end else begin
            blank_n_r <= tap_out_s[2];
            hs_r      <= tap_out_s[1] ? SYNC_POL : ~SYNC_POL;
            vs_r      <= tap_out_s[0] ? SYNC_POL : ~SYNC_POL;
            if (tap_out_s[2]) begin
                red_r <= iR;
                grn_r <= iG;
                blu_r <= iB;
            end else begin
                red_r <= 8'd0;
                grn_r <= 8'd0;
                blu_r <= 8'd0;
            end
        end
    end

    assign ox       = h_r;
    assign oy       = v_r;
    assign oFrame   = frame_r;
    assign oVGA_R   = red_r;
    assign oVGA_G   = grn_r;
    assign oVGA_B   = blu_r;
    assign oHS      = hs_r;
    assign oVS      = vs_r;
    assign oBLANK_N = blank_n_r;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: 800-clock lines as in 640x480, but a short
// 15-line frame (8 active, FP 2, sync 2, BP 3) so several frames fit the run.
module tb_vga_scan_gen;

    localparam int VA = 8;
    localparam int VT = 15;
    localparam int FRAME_CLKS = 800 * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  iR = 8'd0;
    logic [7:0]  iG = 8'd0;
    logic [7:0]  iB = 8'hFF;
    logic [10:0] ox;
    logic [10:0] oy;
    logic [7:0]  oVGA_R;
    logic [7:0]  oVGA_G;
    logic [7:0]  oVGA_B;
    logic        oHS;
    logic        oVS;
    logic        oBLANK_N;
    logic        oFrame;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_scan_gen #(
        .V_ACTIVE (VA),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .PIPE     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iR       (iR),
        .iG       (iG),
        .iB       (iB),
        .ox       (ox),
        .oy       (oy),
        .oVGA_R   (oVGA_R),
        .oVGA_G   (oVGA_G),
        .oVGA_B   (oVGA_B),
        .oHS      (oHS),
        .oVS      (oVS),
        .oBLANK_N (oBLANK_N),
        .oFrame   (oFrame)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Bench-side reference state
    logic [10:0] ex = 11'd0, ey = 11'd0;
    logic [10:0] xh [3];
    logic [10:0] yh [3];
    logic [2:0]  rst_hist = 3'b000;
    int cyc = 0, model_err = 0;
    int t656 = -1, hs_fall_lag = -1, hs_width = -1, hs_period = -1, last_hs_fall = -1;
    int hs_falls_since = 0;
    int t_vs_coord = -1, vs_fall_lag = -1, vs_width = -1, last_vs_fall = -1;
    int n_frames = 0, last_frame = -1, frame_period = -1, blank_cnt = 0, frame_blank = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    // One clock: update the reference, compare every output, measure timing,
    // then drive the 2-clock-latency pixel source.
    task automatic step();
        logic        edge_rst, e_frame, ok, e_act, e_hs, e_vs;
        logic [10:0] px, py;
        logic [59:0] obs_v, exp_v;
        @(posedge clk);
        edge_rst = rst_n;
        rst_hist = {rst_hist[1:0], rst_n};
        #1;
        cyc++;
        if (!edge_rst) begin
            ex = 11'd0; ey = 11'd0; e_frame = 1'b0;
        end else begin
            e_frame = (ex == 11'd799) && (ey == 11'(VA - 1));
            if (ex == 11'd799) begin
                ex = 11'd0;
                ey = (ey == 11'(VT - 1)) ? 11'd0 : ey + 11'd1;
            end else begin
                ex = ex + 11'd1;
            end
        end
        ok    = &rst_hist;
        px    = xh[2];
        py    = yh[2];
        e_act = ok && (px < 11'd640) && (py < 11'(VA));
        e_hs  = !(ok && (px >= 11'd656) && (px < 11'd752));
        e_vs  = !(ok && (py >= 11'd10) && (py < 11'd12));
        exp_v = {ex, ey, e_hs, e_vs, e_act,
                 e_act ? px[7:0] : 8'd0, e_act ? py[7:0] : 8'd0, e_act ? 8'hFF : 8'd0, e_frame};
        obs_v = {ox, oy, oHS, oVS, oBLANK_N, oVGA_R, oVGA_G, oVGA_B, oFrame};
        if (obs_v !== exp_v) begin
            if (model_err == 0)
                $display("first model divergence at cycle %0d: obs %h exp %h", cyc, obs_v, exp_v);
            model_err++;
        end
        if (ox == 11'd656) t656 = cyc;
        if (ox == 11'd0 && oy == 11'd10) t_vs_coord = cyc;
        if (prev_hs === 1'b1 && oHS === 1'b0) begin
            hs_fall_lag = cyc - t656;
            if (last_hs_fall >= 0) hs_period = cyc - last_hs_fall;
            last_hs_fall = cyc;
            hs_falls_since++;
        end
        if (prev_hs === 1'b0 && oHS === 1'b1) hs_width = cyc - last_hs_fall;
        if (prev_vs === 1'b1 && oVS === 1'b0) begin
            vs_fall_lag  = cyc - t_vs_coord;
            last_vs_fall = cyc;
        end
        if (prev_vs === 1'b0 && oVS === 1'b1) vs_width = cyc - last_vs_fall;
        if (oFrame === 1'b1) begin
            if (n_frames > 0) begin
                frame_period = cyc - last_frame;
                frame_blank  = blank_cnt;
            end
            blank_cnt  = 0;
            last_frame = cyc;
            n_frames++;
        end
        if (oBLANK_N === 1'b1) blank_cnt++;
        prev_hs = oHS;
        prev_vs = oVS;
        iR = xh[1][7:0];
        iG = yh[1][7:0];
        xh[2] = xh[1]; xh[1] = xh[0]; xh[0] = ox;
        yh[2] = yh[1]; yh[1] = yh[0]; yh[0] = oy;
    endtask

    task automatic run_to(input int x, input int y, input int budget);
        int n = 0;
        while (!(ox == 11'(x) && oy == 11'(y)) && n < budget) begin
            step();
            n++;
        end
        check_val("run_to_reached", 32'(ox == 11'(x) && oy == 11'(y)), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            xh[i] = 11'd0;
            yh[i] = 11'd0;
        end
        rst_n = 1'b0;
        repeat (5) step();
        check_val("rst_ox", 32'(ox), 32'd0);
        check_val("rst_oy", 32'(oy), 32'd0);
        check_val("rst_hs", 32'(oHS), 32'd1);
        check_val("rst_vs", 32'(oVS), 32'd1);
        check_val("rst_blank_n", 32'(oBLANK_N), 32'd0);
        check_val("rst_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
        check_val("rst_frame", 32'(oFrame), 32'd0);

        rst_n = 1'b1;
        step();
        check_val("rel1_ox", 32'(ox), 32'd1);
        check_val("rel1_oy", 32'(oy), 32'd0);
        step();
        check_val("rel2_blank_n", 32'(oBLANK_N), 32'd0);
        step();
        check_val("pix00_blank_n", 32'(oBLANK_N), 32'd1);
        check_val("pix00_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h0000FF);
        repeat (796) step();
        check_val("rel799_ox", 32'(ox), 32'd799);
        check_val("rel799_oy", 32'(oy), 32'd0);
        step();
        check_val("rel800_ox", 32'(ox), 32'd0);
        check_val("rel800_oy", 32'(oy), 32'd1);

        for (int i = 0; i < 2 * FRAME_CLKS && n_frames < 2; i++) step();
        check_val("frame_count", 32'(n_frames), 32'd2);
        check_val("frame_period", 32'(frame_period), 32'(FRAME_CLKS));
        check_val("blank_n_per_frame", 32'(frame_blank), 32'(640 * VA));
        check_val("hs_fall_lag", 32'(hs_fall_lag), 32'd3);
        check_val("hs_width", 32'(hs_width), 32'd96);
        check_val("hs_period", 32'(hs_period), 32'd800);
        check_val("vs_fall_lag", 32'(vs_fall_lag), 32'd3);
        check_val("vs_width", 32'(vs_width), 32'd1600);

        run_to(700, 11, FRAME_CLKS);
        check_val("pre_mid_hs", 32'(oHS), 32'd0);
        check_val("pre_mid_vs", 32'(oVS), 32'd0);
        rst_n = 1'b0;
        step();
        check_val("mid_rst_ox", 32'(ox), 32'd0);
        check_val("mid_rst_oy", 32'(oy), 32'd0);
        check_val("mid_rst_hs", 32'(oHS), 32'd1);
        check_val("mid_rst_vs", 32'(oVS), 32'd1);
        check_val("mid_rst_blank_n", 32'(oBLANK_N), 32'd0);
        check_val("mid_rst_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        hs_falls_since = 0;
        step();
        check_val("mid_rel_ox", 32'(ox), 32'd1);
        run_to(656, 0, 1000);
        check_val("no_early_hs", 32'(hs_falls_since), 32'd0);
        repeat (2) step();
        check_val("hs_before_lag", 32'(oHS), 32'd1);
        step();
        check_val("hs_after_lag", 32'(oHS), 32'd0);
        check_val("hs_falls_line0", 32'(hs_falls_since), 32'd1);
        repeat (200) step();

        check_val("model_mismatches", 32'(model_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
